// File: rtl/vga_scan.sv
// VGA raster scanner: pixel-rate divider, h/v counters, sync generation and a
// registered output stage that picks the visible colour from the layer inputs.
module vga_scan #(
  parameter int DIV    = 4,
  parameter int H_DISP = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_DISP = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] spr0_rgb,
  input  logic        spr0_on,
  input  logic [11:0] spr1_rgb,
  input  logic        spr1_on,
  input  logic [11:0] bg_rgb,
  output logic [9:0]  xg,
  output logic [9:0]  yg,
  output logic        pixel_tick,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb_out,
  output logic        frame_start
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT  = 10'(H_DISP);
  localparam logic [9:0] V_ACT  = 10'(V_DISP);
  localparam logic [9:0] HS_BEG = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END = 10'(V_DISP + V_FP + V_SYNC);

  logic [CW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          video_on_q, video_on_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          h_end, v_end, active;
  logic [11:0]   pix_rgb;

  always_comb begin
    pixel_tick = (div_q == DIV_LAST);
    div_d      = pixel_tick ? '0 : div_q + CW'(1);
    h_end      = (h_q == H_LAST);
    v_end      = (v_q == V_LAST);
    h_d        = h_q;
    v_d        = v_q;
    if (pixel_tick) begin
      h_d = h_end ? 10'd0 : h_q + 10'd1;
      if (h_end) v_d = v_end ? 10'd0 : v_q + 10'd1;
    end

    // Layer inputs belong to the pixel at the pre-advance counters; off-screen
    // they are discarded so the DAC sees black during blanking.
    active = (h_q < H_ACT) && (v_q < V_ACT);
    if (!active)      pix_rgb = 12'h000;
    else if (spr0_on) pix_rgb = spr0_rgb;
    else if (spr1_on) pix_rgb = spr1_rgb;
    else              pix_rgb = bg_rgb;

    video_on_d = video_on_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    rgb_d      = rgb_q;
    if (pixel_tick) begin
      video_on_d = active;
      hsync_d    = !((h_q >= HS_BEG) && (h_q < HS_END));
      vsync_d    = !((v_q >= VS_BEG) && (v_q < VS_END));
      rgb_d      = pix_rgb;
    end

    frame_start = pixel_tick && h_end && v_end;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q      <= '0;
      h_q        <= 10'd0;
      v_q        <= 10'd0;
      video_on_q <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      rgb_q      <= 12'h000;
    end else begin
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      video_on_q <= video_on_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      rgb_q      <= rgb_d;
    end
  end

  assign xg       = h_q;
  assign yg       = v_q;
  assign video_on = video_on_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign rgb_out  = rgb_q;

endmodule

// File: tb/tb_vga_scan.sv
// Directed bench for vga_scan using a shrunken raster (24x19 total, 16x12
// visible) so whole lines and frames fit in a short run.
module tb_vga_scan;
  localparam int DIV     = 4;
  localparam int H_DISP  = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_DISP  = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int H_TOTAL = 24;
  localparam int V_TOTAL = 19;

  logic        clk, rst;
  logic [11:0] spr0_rgb, spr1_rgb, bg_rgb;
  logic        spr0_on, spr1_on;
  logic [9:0]  xg, yg;
  logic        pixel_tick, video_on, hsync, vsync, frame_start;
  logic [11:0] rgb_out;

  int checks = 0;
  int passes = 0;
  int tick_timeouts = 0;
  logic [31:0] exp_q[$];

  vga_scan #(
    .DIV(DIV), .H_DISP(H_DISP), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISP(V_DISP), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .rst(rst),
    .spr0_rgb(spr0_rgb), .spr0_on(spr0_on),
    .spr1_rgb(spr1_rgb), .spr1_on(spr1_on),
    .bg_rgb(bg_rgb),
    .xg(xg), .yg(yg), .pixel_tick(pixel_tick), .video_on(video_on),
    .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out), .frame_start(frame_start)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Runs from a negedge through the next tick edge; returns clks consumed,
  // number of frame_start samples seen, and the counters before the advance.
  task automatic next_tick(output int n, output int fs_cnt, output int ph, output int pv);
    logic seen;
    n = 0; fs_cnt = 0; ph = int'(xg); pv = int'(yg);
    for (int i = 0; i < 4 * DIV; i++) begin
      seen = pixel_tick;
      if (frame_start) fs_cnt++;
      ph = int'(xg);
      pv = int'(yg);
      @(posedge clk);
      n++;
      @(negedge clk);
      if (seen) return;
    end
    n = -1;
    tick_timeouts++;
  endtask

  task automatic goto_pos(input int h, input int v);
    int n, f, ph, pv;
    for (int i = 0; i < 2 * H_TOTAL * V_TOTAL; i++) begin
      if (int'(xg) == h && int'(yg) == v) break;
      next_tick(n, f, ph, pv);
    end
    chk("goto_pos", {6'd0, xg, 6'd0, yg}, {6'd0, 10'(h), 6'd0, 10'(v)});
  endtask

  initial begin
    int n, f, ph, pv;
    int hs_low, hs_first, vid, rgb_bad;
    int vs_low, fs_total, fs_pos_bad, pos_bad, vid_bad, ex, ey;

    rst = 1'b0;
    spr0_rgb = 12'hF00; spr1_rgb = 12'h0F0; bg_rgb = 12'h00F;
    spr0_on = 1'b1; spr1_on = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_xg", 32'(xg), 32'd0);
    chk("rst_yg", 32'(yg), 32'd0);
    chk("rst_pixel_tick", 32'(pixel_tick), 32'd0);
    chk("rst_video_on", 32'(video_on), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_rgb", 32'(rgb_out), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);

    // first tick comes DIV clks after release, then every DIV clks
    rst = 1'b1;
    next_tick(n, f, ph, pv);
    chk("first_tick_clks", 32'(n), 32'(DIV));
    chk("first_tick_xg", 32'(xg), 32'd1);
    chk("first_tick_video_on", 32'(video_on), 32'd1);
    chk("first_tick_rgb", 32'(rgb_out), 32'hF00);
    next_tick(n, f, ph, pv);
    chk("tick_period", 32'(n), 32'(DIV));
    chk("second_tick_xg", 32'(xg), 32'd2);

    // layer priority at an on-screen pixel
    goto_pos(5, 3);
    exp_q.push_back(32'hF00);
    next_tick(n, f, ph, pv);
    chk("prio_both_on", 32'(rgb_out), exp_q.pop_front());
    spr0_on = 1'b0;
    exp_q.push_back(32'h0F0);
    next_tick(n, f, ph, pv);
    chk("prio_spr1", 32'(rgb_out), exp_q.pop_front());
    spr1_on = 1'b0;
    exp_q.push_back(32'h00F);
    next_tick(n, f, ph, pv);
    chk("prio_bg", 32'(rgb_out), exp_q.pop_front());
    bg_rgb = 12'h0AA;
    repeat (2) @(negedge clk);
    chk("hold_between_ticks", 32'(rgb_out), 32'h00F);

    // one full line
    bg_rgb = 12'hFFF;
    goto_pos(0, 5);
    hs_low = 0; hs_first = -1; vid = 0; rgb_bad = 0;
    for (int i = 0; i < H_TOTAL; i++) begin
      next_tick(n, f, ph, pv);
      if (!hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = ph;
      end
      if (video_on) vid++;
      if (ph >= H_DISP && rgb_out !== 12'h000) rgb_bad++;
      if (ph < H_DISP && rgb_out !== 12'hFFF) rgb_bad++;
    end
    chk("line_hsync_low_ticks", 32'(hs_low), 32'(H_SYNC));
    chk("line_hsync_first_h", 32'(hs_first), 32'(H_DISP + H_FP));
    chk("line_video_on_ticks", 32'(vid), 32'(H_DISP));
    chk("line_rgb_blanking", 32'(rgb_bad), 32'd0);

    // one full frame
    goto_pos(0, 0);
    vs_low = 0; fs_total = 0; fs_pos_bad = 0; pos_bad = 0; vid_bad = 0;
    rgb_bad = 0; ex = 0; ey = 0;
    for (int i = 0; i < H_TOTAL * V_TOTAL; i++) begin
      next_tick(n, f, ph, pv);
      if (ph != ex || pv != ey) pos_bad++;
      if (!vsync) vs_low++;
      fs_total += f;
      if (f != 0 && !(ph == H_TOTAL - 1 && pv == V_TOTAL - 1)) fs_pos_bad++;
      if (video_on !== (ex < H_DISP && ey < V_DISP)) vid_bad++;
      if ((ex >= H_DISP || ey >= V_DISP) && rgb_out !== 12'h000) rgb_bad++;
      ex++;
      if (ex == H_TOTAL) begin
        ex = 0;
        ey = (ey == V_TOTAL - 1) ? 0 : ey + 1;
      end
    end
    chk("frame_counter_sequence", 32'(pos_bad), 32'd0);
    chk("frame_vsync_low_ticks", 32'(vs_low), 32'(V_SYNC * H_TOTAL));
    chk("frame_start_pulses", 32'(fs_total), 32'd1);
    chk("frame_start_position", 32'(fs_pos_bad), 32'd0);
    chk("frame_video_on", 32'(vid_bad), 32'd0);
    chk("frame_rgb_blanking", 32'(rgb_bad), 32'd0);
    chk("frame_wrap_pos", {6'd0, xg, 6'd0, yg}, 32'd0);

    // reset in the middle of the sync pulses
    goto_pos(19, 14);
    chk("pre_rst_hsync", 32'(hsync), 32'd0);
    chk("pre_rst_vsync", 32'(vsync), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_xg", 32'(xg), 32'd0);
    chk("mid_rst_yg", 32'(yg), 32'd0);
    chk("mid_rst_hsync", 32'(hsync), 32'd1);
    chk("mid_rst_vsync", 32'(vsync), 32'd1);
    chk("mid_rst_rgb", 32'(rgb_out), 32'd0);
    chk("mid_rst_pixel_tick", 32'(pixel_tick), 32'd0);
    rst = 1'b1;
    next_tick(n, f, ph, pv);
    chk("post_rst_tick_clks", 32'(n), 32'(DIV));
    chk("post_rst_xg", 32'(xg), 32'd1);

    chk("tick_timeouts", 32'(tick_timeouts), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/vga_scan.md
VGA_SCAN -- requirements
Module: vga_scan

Interface
REQ-001 Parameter DIV, default 4: clk cycles per pixel (100 MHz clk gives a 25 MHz pixel rate).
REQ-002 Parameters H_DISP/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels.
REQ-003 Parameters V_DISP/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 spr0_rgb  input  12  colour from highest-priority sprite layer.
REQ-007 spr0_on  input  1  spr0 pixel opaque.
REQ-008 spr1_rgb  input  12  second sprite layer colour.
REQ-009 spr1_on  input  1  spr1 pixel opaque.
REQ-010 bg_rgb  input  12  background colour.
REQ-011 xg  output  10  current pixel column handed to display layers.
REQ-012 yg  output  10  current pixel row handed to display layers.
REQ-013 pixel_tick  output  1  one-clk strobe per pixel period.
REQ-014 video_on  output  1  registered active-area flag, aligned with rgb_out.
REQ-015 hsync  output  1  active-low horizontal sync, aligned with rgb_out.
REQ-016 vsync  output  1  active-low vertical sync, aligned with rgb_out.
REQ-017 rgb_out  output  12  final pixel colour to DAC pins.
REQ-018 frame_start  output  1  one-clk pulse at frame wrap.

Function
REQ-019 div_cnt: counts 0..DIV-1 and wraps; pixel_tick SHALL be high in exactly the clk where div_cnt==DIV-1.
REQ-020 h_cnt SHALL advance only on pixel_tick; range 0..H_TOTAL-1 (H_TOTAL=800); wraps to 0.
REQ-021 v_cnt SHALL advance only on a pixel_tick where h_cnt==H_TOTAL-1; range 0..V_TOTAL-1 (V_TOTAL=525); wraps to 0.
REQ-022 xg=h_cnt and yg=v_cnt, driven directly from the counters (no extra delay).
REQ-023 Layer ROMs have one clk of read latency; inputs SHALL be sampled only on a pixel_tick edge, at least DIV-1 clks after xg/yg last changed.
REQ-024 On each pixel_tick, the output stage SHALL register values computed from the pre-advance h_cnt/v_cnt: video_on=(h<H_DISP && v<V_DISP), hsync=0 iff H_DISP+H_FP <= h < H_DISP+H_FP+H_SYNC (656..751), vsync=0 iff V_DISP+V_FP <= v < V_DISP+V_FP+V_SYNC (490..491), and rgb_out.
REQ-025 rgb_out SHALL be 12'h000 when not active; otherwise spr0_rgb if spr0_on, else spr1_rgb if spr1_on, else bg_rgb.
REQ-026 Output stage latency: exactly one pixel period (DIV clks) behind xg/yg; outputs SHALL hold between ticks.
REQ-027 frame_start SHALL be high for one clk, on the pixel_tick where h_cnt==799 and v_cnt==524 (simultaneous h and v wrap).
REQ-028 Both sprite on flags high: spr0 wins. Inputs outside the active area SHALL be ignored.
REQ-029 Counter widths: 10 bits each; no value outside the stated ranges SHALL ever occur.

Reset
REQ-030 While rst==0 at a clk edge: div_cnt, h_cnt, v_cnt = 0; pixel_tick, video_on, frame_start, rgb_out = 0; hsync, vsync = 1.
REQ-031 Reset asserted mid-line or mid-frame SHALL restart all counters from 0 on the next edge; there is no partial-frame recovery.
REQ-032 After release, the first pixel_tick SHALL occur DIV clks later.

Verification
REQ-033 Release reset, count clks -> pixel_tick period 4 clks; h_cnt wraps 799->0 after 3200 clks; v_cnt wraps after 1,680,000 clks.
REQ-034 Scan one line -> hsync low for exactly 96 ticks, starting on the tick that registers h=656; video_on high for 640 ticks.
REQ-035 Scan one frame -> vsync low for exactly 2 lines (v=490,491); frame_start pulses once per 420,000 ticks.
REQ-036 Set spr0_on=1 with spr0_rgb=12'hF00, spr1_on=1 with 12'h0F0, bg=12'h00F at x=100,y=100 -> rgb_out=12'hF00. Same test with spr0_on=0 -> 12'h0F0. Both on flags 0 -> 12'h00F.
REQ-037 Drive bg_rgb=12'hFFF constantly -> rgb_out=0 whenever h>=640 or v>=480.
REQ-038 Assert rst at h=300,v=200 for 1 clk -> next edge shows xg=0, yg=0, hsync=vsync=1, rgb_out=0.
